// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: one shift-add or restoring-subtract step per cycle.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, DIV/REM overflow and MUL* with a zero operand finish without iterating.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] Rd1_i,
  input  logic [XLEN-1:0] Rd2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  // state | meaning
  // IDLE  | waiting for an M-op in ID/EX
  // BUSY  | iterating, one step per cycle
  // DONE  | result_o valid, ID/EX released
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] hi, lo, opnd;
  logic            op_div, op_hi, neg_res, neg_rem, div_zero;

  logic            is_mop, is_div_in, sgn1, sgn2, neg1, neg2;
  logic [2:0]      f3;
  logic [XLEN-1:0] abs1, abs2;
  logic            unused_inst;

  assign is_mop    = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
  assign f3        = inst_i[14:12];
  assign is_div_in = f3[2];
  assign sgn1      = f3[2] ? ~f3[0] : (f3 != 3'd3);
  assign sgn2      = f3[2] ? ~f3[0] : ~f3[1];
  assign neg1      = sgn1 & Rd1_i[XLEN-1];
  assign neg2      = sgn2 & Rd2_i[XLEN-1];
  assign abs1      = neg1 ? -Rd1_i : Rd1_i;
  assign abs2      = neg2 ? -Rd2_i : Rd2_i;
  assign unused_inst = ^{inst_i[24:15], inst_i[11:7]};

  // hi/lo hold product high/low for MUL*, remainder/quotient for DIV/REM*
  logic [XLEN:0]   sum, shifted;
  logic [XLEN-1:0] diff, nxt_hi, nxt_lo;
  logic            ge;

  assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign shifted = {hi, lo[XLEN-1]};
  assign ge      = (shifted >= {1'b0, opnd});
  assign diff    = shifted[XLEN-1:0] - opnd;
  assign nxt_hi  = op_div ? (ge ? diff : shifted[XLEN-1:0]) : sum[XLEN:1];
  assign nxt_lo  = op_div ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   mul_res, quo, rem, div_res;

  assign prod    = {nxt_hi, nxt_lo};
  assign prod_s  = neg_res ? -prod : prod;
  assign mul_res = op_hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
  // A zero divisor leaves the quotient all ones; it must not be sign-flipped
  assign quo     = div_zero ? {XLEN{1'b1}} : (neg_res ? -nxt_lo : nxt_lo);
  assign rem     = neg_rem ? -nxt_hi : nxt_hi;
  assign div_res = op_hi ? rem : quo;

  logic            early_hit;
  logic [XLEN-1:0] early_res;

`ifdef MULDIV_EARLY_OUT_EN
  logic div_by_zero_in, div_ovf_in;
  assign div_by_zero_in = (Rd2_i == '0);
  assign div_ovf_in     = ~f3[0] && (Rd1_i == {1'b1, {(XLEN-1){1'b0}}}) && (Rd2_i == {XLEN{1'b1}});
  assign early_hit = is_div_in ? (div_by_zero_in || div_ovf_in) : ((Rd1_i == '0) || (Rd2_i == '0));
  always_comb begin
    early_res = '0;
    if (is_div_in) begin
      if (div_by_zero_in) early_res = f3[1] ? Rd1_i : {XLEN{1'b1}};
      else                early_res = f3[1] ? '0 : Rd1_i;
    end
  end
`else
  assign early_hit = 1'b0;
  assign early_res = '0;
`endif

  assign stall_o = ((state == IDLE) && is_mop) || (state == BUSY);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      op_div   <= 1'b0;
      op_hi    <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      state  <= IDLE;
      cnt    <= '0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (is_mop) begin
            if (early_hit) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= early_res;
            end else begin
              state    <= BUSY;
              cnt      <= '0;
              op_div   <= is_div_in;
              op_hi    <= is_div_in ? f3[1] : (f3 != 3'd0);
              neg_res  <= neg1 ^ neg2;
              neg_rem  <= neg1;
              div_zero <= is_div_in && (Rd2_i == '0);
              hi       <= '0;
              lo       <= is_div_in ? abs1 : abs2;
              opnd     <= is_div_in ? abs2 : abs1;
            end
          end
        end
        BUSY: begin
          hi  <= nxt_hi;
          lo  <= nxt_lo;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN-1)) begin
            state    <= DONE;
            done_o   <= 1'b1;
            result_o <= op_div ? div_res : mul_res;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit; expected values are hand-computed.
module tb_ex_muldiv_unit;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] inst_i, Rd1_i, Rd2_i;
  logic        flush_i;
  logic        stall_o, done_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  localparam int LAT_FULL = 33;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_EO = 1;
`else
  localparam int LAT_EO = 33;
`endif

  ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_i(inst_i), .Rd1_i(Rd1_i), .Rd2_i(Rd2_i),
    .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge with the unit idle; leaves inst_i as ADD after the DONE edge
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int   lat;
    int   stall_cnt;
    logic seen;
    logic stall_at_done;
    inst_i = mk(7'b0000001, f3);
    Rd1_i  = a;
    Rd2_i  = b;
    lat = 999; stall_cnt = 0; seen = 1'b0; stall_at_done = 1'bx;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        seen = 1'b1;
        lat = i;
        stall_at_done = stall_o;
      end else if (stall_o === 1'b1) begin
        stall_cnt++;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " stall cycles"}, stall_cnt, exp_lat);
    chk({tag, " result"}, result_o, exp);
    chk({tag, " stall in done"}, {31'd0, stall_at_done}, 32'd0);
    @(posedge clk_i); #1;
    inst_i = mk(7'b0000000, 3'd0);
  endtask

  initial begin
    int dcount;
    rst_i = 1'b0; flush_i = 1'b0;
    inst_i = mk(7'b0000000, 3'd0); Rd1_i = '0; Rd2_i = '0;
    repeat (3) @(posedge clk_i); #1;
    chk("reset done", {31'd0, done_o}, 32'd0);
    chk("reset result", result_o, 32'd0);
    chk("reset stall add", {31'd0, stall_o}, 32'd0);
    inst_i = mk(7'b0000001, 3'd0); #1;
    chk("reset stall mop", {31'd0, stall_o}, 32'd1);
    inst_i = mk(7'b0000000, 3'd0);
    @(posedge clk_i); #1; rst_i = 1'b1;
    @(posedge clk_i); #1;

    Rd1_i = 32'd5; Rd2_i = 32'd6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("add stall", {31'd0, stall_o}, 32'd0);
      chk("add done", {31'd0, done_o}, 32'd0);
    end
    @(posedge clk_i); #1;

    run_op("mul",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_FULL);
    run_op("mulhu",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_FULL);
    run_op("mulh",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT_FULL);
    run_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_FULL);
    run_op("div ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_EO);
    run_op("rem ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_EO);
    run_op("divu /0",  3'd5, 32'd100,      32'd0,        32'hFFFFFFFF, LAT_EO);
    run_op("remu /0",  3'd7, 32'd100,      32'd0,        32'd100,      LAT_EO);
    run_op("div neg/0",3'd4, 32'hFFFFFFEC, 32'd0,        32'hFFFFFFFF, LAT_EO);
    run_op("rem neg/0",3'd6, 32'hFFFFFFEC, 32'd0,        32'hFFFFFFEC, LAT_EO);
    run_op("div b2b",  3'd4, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, LAT_FULL);
    run_op("rem b2b",  3'd6, 32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, LAT_FULL);

    // Reset asserted mid-iteration
    inst_i = mk(7'b0000001, 3'd0); Rd1_i = 32'd9; Rd2_i = 32'd9;
    repeat (10) @(posedge clk_i); #1;
    chk("pre-reset busy stall", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b0; #1;
    chk("mid reset done", {31'd0, done_o}, 32'd0);
    chk("mid reset result", result_o, 32'd0);
    chk("mid reset stall decode", {31'd0, stall_o}, 32'd1);
    inst_i = mk(7'b0000000, 3'd0);
    @(posedge clk_i); #1; rst_i = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) dcount++;
    end
    chk("no done after reset", dcount, 0);
    @(posedge clk_i); #1;

    // Flush mid-iteration
    inst_i = mk(7'b0000001, 3'd4); Rd1_i = 32'd50; Rd2_i = 32'd7;
    repeat (10) @(posedge clk_i); #1;
    chk("pre-flush busy stall", {31'd0, stall_o}, 32'd1);
    flush_i = 1'b1; inst_i = mk(7'b0000000, 3'd0);
    @(posedge clk_i); #1; flush_i = 1'b0;
    chk("flush idle stall", {31'd0, stall_o}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) dcount++;
    end
    chk("no done after flush", dcount, 0);
    @(posedge clk_i); #1;

    run_op("mul recover", 3'd0, 32'h12345678, 32'h00000010, 32'h23456780, LAT_FULL);
    run_op("mul x*0",     3'd0, 32'h12345678, 32'h00000000, 32'h00000000, LAT_EO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
